// File: rtl/acia_rx_deserialiser_if.sv
// Received-byte handshake between the ACIA receive deserialiser and the register file.
interface acia_rx_deserialiser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/acia_rx_deserialiser.sv
// ACIA receive deserialiser: samples the ULA RxC/RxD/DCD trio and assembles async frames.
// Optional parity support is built when ACIA_RX_PARITY_EN is defined.
module acia_rx_deserialiser #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_BITS   = 8
) (
    input  logic                          clk,
    input  logic                          nRST,
    input  logic                          RxC,
    input  logic                          RxD,
    input  logic                          DCD,
    input  logic [1:0]                    div_sel,
    input  logic                          par_en,
    input  logic                          par_odd,
    acia_rx_deserialiser_if.master        rx,
    input  logic                          clr_status,
    output logic                          framing_err,
    output logic                          overrun,
    output logic                          parity_err,
    output logic                          dcd_seen
);
    localparam int unsigned TICK_W = 6;
    localparam int unsigned BIT_W  = 3;
    localparam logic [1:0]  DIV_X1  = 2'b00;
    localparam logic [1:0]  DIV_X16 = 2'b01;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] rxc_sync_q, rxc_sync_d;
    logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
    logic [SYNC_STAGES-1:0] dcd_sync_q, dcd_sync_d;
    logic                 rxc_prev_q, rxd_prev_q, dcd_prev_q;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [1:0]           div_q, div_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;
    logic                 dcd_seen_q, dcd_seen_d;

    logic                 rxc_s, rxd_s, dcd_s;
    logic                 tick_c, rxd_fall_c, dcd_rise_c;
    logic                 sample_now_c, complete_c, accept_c;
    logic                 is_x1_c, is_x16_c;
    logic [TICK_W-1:0]    half_last_c, full_last_c, cnt_next_c;

`ifdef ACIA_RX_PARITY_EN
    logic                 par_acc_q, par_acc_d;
    logic                 par_mis_q, par_mis_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_par_c;
    assign unused_par_c = par_en ^ par_odd;
`endif

    assign rxc_s = rxc_sync_q[SYNC_STAGES-1];
    assign rxd_s = rxd_sync_q[SYNC_STAGES-1];
    assign dcd_s = dcd_sync_q[SYNC_STAGES-1];

    // Edge detectors on the synchronised inputs; tick is one clk wide.
    assign tick_c     = rxc_s & ~rxc_prev_q;
    assign rxd_fall_c = rxd_prev_q & ~rxd_s;
    assign dcd_rise_c = dcd_s & ~dcd_prev_q;

    // Sample cadence derived from the divide latched at frame start.
    assign is_x1_c      = (div_q == DIV_X1);
    assign is_x16_c     = (div_q == DIV_X16);
    assign half_last_c  = is_x16_c ? TICK_W'(7)  : TICK_W'(31);
    assign full_last_c  = is_x16_c ? TICK_W'(15) : TICK_W'(63);
    assign sample_now_c = tick_c & (is_x1_c | (tick_cnt_q == full_last_c));
    assign cnt_next_c   = sample_now_c ? '0 : tick_cnt_q + TICK_W'(1);
    assign accept_c     = rx_valid_q & rx.rx_ready;

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_idx_d     = bit_idx_q;
        div_d         = div_q;
        shift_d       = shift_q;
        complete_c    = 1'b0;
        rxc_sync_d    = {rxc_sync_q[SYNC_STAGES-2:0], RxC};
        rxd_sync_d    = {rxd_sync_q[SYNC_STAGES-2:0], RxD};
        dcd_sync_d    = {dcd_sync_q[SYNC_STAGES-2:0], DCD};
`ifdef ACIA_RX_PARITY_EN
        par_acc_d     = par_acc_q;
        par_mis_d     = par_mis_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (div_sel == DIV_X1) begin
                    if (tick_c && !rxd_s) begin
                        state_d    = ST_DATA;
                        bit_idx_d  = '0;
                        tick_cnt_d = '0;
                        div_d      = div_sel;
`ifdef ACIA_RX_PARITY_EN
                        par_acc_d  = 1'b0;
                        par_mis_d  = 1'b0;
`endif
                    end
                end else if (rxd_fall_c) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    div_d      = div_sel;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (tick_cnt_q == half_last_c) begin
                        tick_cnt_d = '0;
                        // A high mid-start sample is a glitch, not a frame.
                        if (!rxd_s) begin
                            state_d   = ST_DATA;
                            bit_idx_d = '0;
`ifdef ACIA_RX_PARITY_EN
                            par_acc_d = 1'b0;
                            par_mis_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) tick_cnt_d = cnt_next_c;
                if (sample_now_c) begin
                    shift_d              = {1'b0, shift_q[7:1]};
                    shift_d[DATA_BITS-1] = rxd_s;
                    bit_idx_d            = bit_idx_q + BIT_W'(1);
`ifdef ACIA_RX_PARITY_EN
                    par_acc_d            = par_acc_q ^ rxd_s;
`endif
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef ACIA_RX_PARITY_EN
                        state_d   = par_en ? ST_PARITY : ST_STOP;
`else
                        state_d   = ST_STOP;
`endif
                    end
                end
            end
`ifdef ACIA_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_c) tick_cnt_d = cnt_next_c;
                if (sample_now_c) begin
                    par_mis_d = par_acc_q ^ rxd_s ^ par_odd;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_c) tick_cnt_d = cnt_next_c;
                if (sample_now_c) begin
                    complete_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte handshake: a completion against an unaccepted byte is dropped.
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q & ~clr_status;
        if (complete_c) begin
            if (!rx_valid_q || accept_c) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end else if (accept_c) begin
            rx_valid_d = 1'b0;
        end

        framing_err_d = (framing_err_q & ~clr_status) | (complete_c & ~rxd_s);
        dcd_seen_d    = (dcd_seen_q & ~clr_status) | dcd_rise_c;
`ifdef ACIA_RX_PARITY_EN
        parity_err_d  = (parity_err_q & ~clr_status) | (complete_c & par_mis_q);
`endif
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= ST_IDLE;
            rxc_sync_q    <= '1;
            rxd_sync_q    <= '1;
            dcd_sync_q    <= '0;
            rxc_prev_q    <= 1'b1;
            rxd_prev_q    <= 1'b1;
            dcd_prev_q    <= 1'b0;
            tick_cnt_q    <= '0;
            bit_idx_q     <= '0;
            div_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            dcd_seen_q    <= 1'b0;
`ifdef ACIA_RX_PARITY_EN
            par_acc_q     <= 1'b0;
            par_mis_q     <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rxc_sync_q    <= rxc_sync_d;
            rxd_sync_q    <= rxd_sync_d;
            dcd_sync_q    <= dcd_sync_d;
            rxc_prev_q    <= rxc_s;
            rxd_prev_q    <= rxd_s;
            dcd_prev_q    <= dcd_s;
            tick_cnt_q    <= tick_cnt_d;
            bit_idx_q     <= bit_idx_d;
            div_q         <= div_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            dcd_seen_q    <= dcd_seen_d;
`ifdef ACIA_RX_PARITY_EN
            par_acc_q     <= par_acc_d;
            par_mis_q     <= par_mis_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign rx.rx_data  = rx_data_q;
    assign rx.rx_valid = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign dcd_seen    = dcd_seen_q;
`ifdef ACIA_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_acia_rx_deserialiser.sv
// Directed bench for acia_rx_deserialiser: expected bytes go to a queue that a monitor drains on accept.
module tb_acia_rx_deserialiser;
    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       RxC = 1'b0;
    logic       RxD = 1'b1;
    logic       DCD = 1'b0;
    logic [1:0] div_sel = 2'b00;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       clr_status = 1'b0;
    logic       framing_err, overrun, parity_err, dcd_seen;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    acia_rx_deserialiser_if rx_if ();

    acia_rx_deserialiser #(.SYNC_STAGES(SYNC), .DATA_BITS(8)) dut (
        .clk         (clk),
        .nRST        (nRST),
        .RxC         (RxC),
        .RxD         (RxD),
        .DCD         (DCD),
        .div_sel     (div_sel),
        .par_en      (par_en),
        .par_odd     (par_odd),
        .rx          (rx_if.master),
        .clr_status  (clr_status),
        .framing_err (framing_err),
        .overrun     (overrun),
        .parity_err  (parity_err),
        .dcd_seen    (dcd_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted byte must match the head of the queue.
    always @(negedge clk) begin
        if (nRST && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%02h required=none", rx_if.rx_data);
            end else begin
                chk("sb_byte", rx_if.rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1 RxC = 1'b1;
        repeat (4) @(posedge clk);
        #1 RxC = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        @(posedge clk); #1 RxD = b;
        repeat (n) tick();
    endtask

    task automatic send_head(input logic [7:0] b, input int n);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(b[i], n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int n);
        send_head(b, n);
        send_bit(stop_b, n);
        send_bit(1'b1, 2);
    endtask

    // x1 stop bit split in two so the caller can act around the stop tick.
    task automatic stop_rise();
        @(posedge clk); #1 RxD = 1'b1;
        @(posedge clk); #1 RxC = 1'b1;
        repeat (SYNC) @(posedge clk);
    endtask

    task automatic stop_fall();
        repeat (3) @(posedge clk);
        #1 RxC = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_status = 1'b1;
        @(posedge clk); #1 clr_status = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1 rx_if.rx_ready = r;
    endtask

    task automatic check_flags(input string tag, input logic fe, input logic ov,
                               input logic pe, input logic dc);
        @(negedge clk);
        chk({tag, "_framing"}, {7'b0, framing_err}, {7'b0, fe});
        chk({tag, "_overrun"}, {7'b0, overrun},     {7'b0, ov});
        chk({tag, "_parity"},  {7'b0, parity_err},  {7'b0, pe});
        chk({tag, "_dcd"},     {7'b0, dcd_seen},    {7'b0, dc});
    endtask

    task automatic check_sb_empty(input string tag);
        chk(tag, 8'(exp_q.size()), 8'h00);
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  rx_if.rx_data, 8'h00);
        chk("rst_valid", {7'b0, rx_if.rx_valid}, 8'h00);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 nRST = 1'b1;
        repeat (4) @(posedge clk);

        // x1 0x55 with stop-tick latency
        div_sel = 2'b00;
        exp_q.push_back(8'h55);
        send_head(8'h55, 1);
        stop_rise();
        @(negedge clk);
        chk("x1_lat_early", {7'b0, rx_if.rx_valid}, 8'h00);
        @(negedge clk);
        chk("x1_lat_rise", {7'b0, rx_if.rx_valid}, 8'h01);
        chk("x1_data", rx_if.rx_data, 8'h55);
        stop_fall();
        check_flags("x1", 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb_empty("x1_sb_empty");

        // x16 0xA3, then a short glitch that must be rejected
        @(posedge clk); #1 div_sel = 2'b01;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 16);
        check_sb_empty("x16_sb_empty");
        send_bit(1'b0, 3);
        send_bit(1'b1, 16);
        @(negedge clk);
        chk("glitch_valid", {7'b0, rx_if.rx_valid}, 8'h00);
        check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

        // x16 0x3C with bad stop bit; byte still delivered
        set_ready(1'b0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 16);
        @(negedge clk);
        chk("fe_valid", {7'b0, rx_if.rx_valid}, 8'h01);
        chk("fe_data", rx_if.rx_data, 8'h3C);
        check_flags("fe", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        check_flags("fe_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        check_sb_empty("fe_sb_empty");

        // x1 overrun: second byte lost, first kept
        @(posedge clk); #1 div_sel = 2'b00;
        set_ready(1'b0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        @(negedge clk);
        chk("ovr_data", rx_if.rx_data, 8'h11);
        chk("ovr_valid", {7'b0, rx_if.rx_valid}, 8'h01);
        check_flags("ovr", 1'b0, 1'b1, 1'b0, 1'b0);
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovr_drained", {7'b0, rx_if.rx_valid}, 8'h00);
        check_sb_empty("ovr_sb_empty");
        pulse_clr();
        check_flags("ovr_clr", 1'b0, 1'b0, 1'b0, 1'b0);

        // accept in the same cycle as the second completion
        set_ready(1'b0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1);
        exp_q.push_back(8'h22);
        send_head(8'h22, 1);
        stop_rise();
        #1 rx_if.rx_ready = 1'b1;
        @(posedge clk); #1 rx_if.rx_ready = 1'b0;
        @(negedge clk);
        chk("same_data", rx_if.rx_data, 8'h22);
        chk("same_valid", {7'b0, rx_if.rx_valid}, 8'h01);
        chk("same_overrun", {7'b0, overrun}, 8'h00);
        stop_fall();
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        check_sb_empty("same_sb_empty");

        // odd parity on 0x07
        @(posedge clk); #1 par_en = 1'b1; par_odd = 1'b1;
`ifdef ACIA_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_head(8'h07, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 2);
        check_flags("par_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h07);
        send_head(8'h07, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 2);
        check_flags("par_bad", 1'b0, 1'b0, 1'b1, 1'b0);
`else
        exp_q.push_back(8'h07);
        send_head(8'h07, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 2);
        check_flags("nopar_ok", 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(8'h07);
        send_head(8'h07, 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b1, 2);
        check_flags("nopar_stop", 1'b1, 1'b0, 1'b0, 1'b0);
`endif
        check_sb_empty("par_sb_empty");
        @(posedge clk); #1 par_en = 1'b0; par_odd = 1'b0;

        // reset mid-DATA with a sticky flag set, then DCD pulse and a fresh frame
        send_bit(1'b0, 1);
        send_bit(1'b1, 1);
        send_bit(1'b0, 1);
        @(posedge clk); #1 nRST = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", rx_if.rx_data, 8'h00);
        chk("mid_rst_valid", {7'b0, rx_if.rx_valid}, 8'h00);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 nRST = 1'b1; RxD = 1'b1;
        repeat (3) @(posedge clk);
        @(posedge clk); #1 DCD = 1'b1;
        @(posedge clk); #1 DCD = 1'b0;
        repeat (4) @(posedge clk);
        check_flags("dcd", 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1);
        check_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

        repeat (4) @(posedge clk);
        check_sb_empty("final_sb_empty");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acia_rx_deserialiser.md
Name: acia_rx_deserialiser

Overview:
- Receive-side stage directly downstream of the serial ULA. Consumes the RxC/RxD/DCD trio it produces (cassette-recovered or RS423-muxed) and deserialises asynchronous frames into bytes for the 6502-side register file.
- Everything runs on the single fast clock. RxC is treated as a sampled signal, not a clock.
- Provides a byte valid/ready handshake plus sticky framing, overrun, parity and carrier status.

Parameters:
- SYNC_STAGES, 2, flops in the RxC/RxD/DCD synchronisers (minimum 2).
- DATA_BITS, 8, data bits per frame, LSB first. Legal values 7 or 8. For 7, rx_data[7] = 0.

Ports:
- clk  in  1  fast clock (16/13 MHz).
- nRST  in  1  asynchronous active-low reset.
- RxC  in  1  receive clock from serial ULA. Its rising edge is the sample tick.
- RxD  in  1  receive data from serial ULA.
- DCD  in  1  carrier-detect from serial ULA. Active-high; may be a single pulse.
- div_sel  in  2  tick divide: 00 = x1, 01 = x16, 10 = x64, 11 = reserved, behaves as x64.
- par_en  in  1  expect a parity bit after the data bits.
- par_odd  in  1  1 = odd parity, 0 = even.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- clr_status  in  1  single-cycle pulse; clears the sticky flags.
- framing_err  out  1  sticky: a stop bit sampled 0.
- overrun  out  1  sticky: a byte was lost.
- parity_err  out  1  sticky: parity mismatch.
- dcd_seen  out  1  sticky: a DCD rising edge was seen.

Behaviour:
- Reset is asynchronous. Any reset, including mid-frame, forces:
  - state IDLE and all counters 0;
  - rx_data = 0 and every output flag = 0;
  - synchroniser flops to 1 for RxC/RxD and 0 for DCD.
- Synchronisers: RxC, RxD and DCD each pass through SYNC_STAGES flops.
  - tick = synchronised RxC rising edge, one clk wide.
  - DCD rising edge after sync sets dcd_seen.
- div_sel is latched on entry to START (x16/x64) or DATA (x1). Changes mid-frame apply from the next frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - x1: on a tick with RxD = 0, go to DATA with bit_idx = 0.
  - x16/x64: on a synchronised RxD falling edge, go to START and clear the tick counter.
- START (x16/x64 only):
  - After 8 (x16) or 32 (x64) ticks, resample RxD.
  - If 0, go to DATA and reset the tick counter.
  - If 1, this is a false start: return to IDLE with no flag change.
- DATA:
  - Sample RxD every tick (x1), every 16th tick (x16) or every 64th tick (x64).
  - Shift samples into the shift register LSB first.
  - After DATA_BITS samples, go to PARITY if par_en, else STOP.
- PARITY: one sample at the same cadence as DATA. Compute the mismatch; its flag is applied on the stop-bit sample. Then go to STOP.
- STOP: one sample at the same cadence, then IDLE. The stop sample completes the frame:
  - framing_err |= (sample == 0);
  - parity_err |= mismatch;
  - deliver the byte per the handshake rules below. The byte is delivered even on a framing error.
- Latency: rx_valid rises on the clk cycle after the stop-sample tick.
- Handshake rules:
  - rx_valid && rx_ready in a cycle with no completion: rx_valid drops next cycle.
  - Completion while rx_valid = 0: load rx_data and set rx_valid.
  - Completion in the same cycle as an accept: load the new byte, rx_valid stays 1, no overrun.
  - Completion while rx_valid = 1 and not accepted: set overrun, discard the new byte, keep the old one.
- rx_data is stable while rx_valid = 1.
- clr_status clears all four sticky flags. A flag set in the same cycle as clr_status wins (stays set).
- Tick counter is 6 bits and wraps at 63. Consecutive tick edges closer than SYNC_STAGES+1 clk are unsupported.

Optional Feature:
- Macro: ACIA_RX_PARITY_EN.
- Defined: PARITY state, parity calculation, and par_en/par_odd/parity_err behaviour as described above.
- Undefined: no PARITY state or parity logic. par_en and par_odd are ignored and parity_err is tied 0. The port list is identical in both builds.

Test Plan:
- x1, frame 0x55 8N1 with one bit per RxC rising edge -> rx_valid rises 1 clk after the stop tick; rx_data = 0x55; all flags 0.
- x16, frame 0xA3 -> rx_data = 0xA3. Separately, a 3-tick low glitch on idle RxD -> false start, no rx_valid, no flags.
- x16, frame 0x3C with stop bit 0 -> rx_data = 0x3C, rx_valid = 1, framing_err = 1. After a clr_status pulse, framing_err = 0.
- rx_ready held 0; frames 0x11 then 0x22 -> rx_data stays 0x11, overrun = 1. Repeat with an accept in the same cycle as the 2nd completion -> rx_data = 0x22, overrun = 0.
- Macro defined, par_en = 1, par_odd = 1, byte 0x07 sent with parity bit 0 -> parity_err = 0. Same byte with parity bit 1 -> parity_err = 1. Macro undefined -> parity_err = 0 and the parity bit is treated as the stop bit.
- nRST asserted mid-DATA, then a single DCD pulse, then a fresh frame 0x81 -> after reset all outputs 0; dcd_seen = 1; next frame decodes as 0x81.
